// File: rtl/mux_2to1_pkg.sv
// Shared limits for the 2:1 select primitive.
// Latency: none (declarations only).
// Backpressure: none.
package mux_2to1_pkg;

  // Supported data width range for the select primitive.
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  // True when a requested data width is inside the supported range.
  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/mux_2to1_core.sv
// Purely combinational 2:1 select: Y = S ? B : A, bitwise over WIDTH.
// Latency: zero cycles, no clock or reset dependency.
// Backpressure: none; output follows inputs continuously.
module mux_2to1_core
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  output logic [WIDTH-1:0] Y
);

  // The conditional operator is kept on purpose: an unknown select merges
  // A and B bitwise, so bits where A==B stay known in simulation.
  assign Y = S ? B : A;

endmodule

// File: rtl/mux_2to1.sv
// 2:1 select with combinational output Y plus a registered copy (Y_q, S_q, sel_chg).
// Latency: Y zero cycles; Y_q/S_q/sel_chg one cycle after an en=1 edge.
// Backpressure: en=0 holds Y_q/S_q and clears sel_chg; Y is never stalled.
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  input  logic             en,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             S_q,
  output logic             sel_chg
);

  // Reject out-of-range widths at elaboration time.
  if (!width_legal(WIDTH)) begin : g_width_check
    $error("mux_2to1: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  mux_2to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A (A),
    .B (B),
    .S (S),
    .Y (Y)
  );

  // Registered stage: load result and select on en, flag a select change
  // against the previously loaded select; reset clears all of it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_q     <= '0;
      S_q     <= 1'b0;
      sel_chg <= 1'b0;
    end else if (en) begin
      Y_q     <= Y;
      S_q     <= S;
      sel_chg <= (S != S_q);
    end else begin
      sel_chg <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // Combinational output obeys the select rule whenever the select is known.
  a_y_rule: assert property (@(posedge clk)
    !$isunknown(S) |-> (Y == (S ? B : A)))
    else $error("mux_2to1: Y does not follow select rule");

  // Back-to-back sel_chg only when the loaded select toggled again.
  a_sel_chg_pair: assert property (@(posedge clk) disable iff (!rst_n)
    (sel_chg && $past(sel_chg)) |-> (S_q != $past(S_q)))
    else $error("mux_2to1: sel_chg high twice without select toggle");
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: WIDTH=1 truth table, WIDTH=8 directed and random.
// Reference model tracks the registered stage from the select/load rules.
module tb_mux_2to1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=1 instance
  logic a1, b1, s1, en1;
  logic y1, yq1, sq1, sc1;

  // WIDTH=8 instance
  logic [7:0] a8, b8, y8, yq8;
  logic       s8, en8, sq8, sc8;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state of the registered stage (WIDTH=8)
  logic [7:0] m_yq;
  logic       m_sq;
  logic       m_sc;

  mux_2to1 #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .S(s1), .en(en1),
    .Y(y1), .Y_q(yq1), .S_q(sq1), .sel_chg(sc1)
  );

  mux_2to1 #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .S(s8), .en(en8),
    .Y(y8), .Y_q(yq8), .S_q(sq8), .sel_chg(sc8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge, check Y, clock once, then check the registers.
  task automatic step8(input logic en, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input string tag);
    logic [7:0] sel;
    @(negedge clk);
    en8 = en; s8 = s; a8 = a; b8 = b;
    sel = s ? b : a;
    #1 check({tag, "_y"}, y8, sel);
    @(posedge clk);
    if (en) begin
      m_sc = (s != m_sq);
      m_sq = s;
      m_yq = sel;
    end else begin
      m_sc = 1'b0;
    end
    #1;
    check({tag, "_yq"}, yq8, m_yq);
    check({tag, "_sq"}, sq8, m_sq);
    check({tag, "_selchg"}, sc8, m_sc);
  endtask

  initial begin
    logic [7:0] tt_exp;
    logic [4:0] seq_s;
    logic [4:0] seq_chg;
    logic [7:0] hold_yq;

    tt_exp  = 8'b1100_1010;
    seq_s   = 5'b01100;   // bit i = S on edge i: 0,0,1,1,0
    seq_chg = 5'b10100;   // bit i = sel_chg after edge i: 0,0,1,0,1

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; s1 = 1'b0; en1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; en8 = 1'b0;
    m_yq = 8'h00; m_sq = 1'b0; m_sc = 1'b0;

    // Reset state, with en high so only reset can keep the registers clear
    en8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; s8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_yq", yq8, 8'h00);
    check("rst_sq", sq8, 1'b0);
    check("rst_selchg", sc8, 1'b0);
    check("rst_yq_w1", yq1, 1'b0);
    check("rst_y_live", y8, 8'hC3);
    en8 = 1'b0;

    // WIDTH=1 truth table in 10-unit steps, still under reset (Y ignores it)
    for (int i = 0; i < 8; i++) begin
      a1 = i[0]; b1 = i[1]; s1 = i[2];
      #10;
      check($sformatf("tt_%0d", i), y1, tt_exp[i]);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=8 select and one-cycle registered follow
    step8(1'b1, 1'b0, 8'hA5, 8'h3C, "w8_s0");
    check("w8_yq_a5", yq8, 8'hA5);
    step8(1'b1, 1'b1, 8'hA5, 8'h3C, "w8_s1");
    check("w8_yq_3c", yq8, 8'h3C);

    // Hold: en low, inputs move, registers stay put
    hold_yq = yq8;
    step8(1'b0, 1'b0, 8'h11, 8'h22, "hold0");
    step8(1'b0, 1'b1, 8'h33, 8'h44, "hold1");
    step8(1'b0, 1'b0, 8'h55, 8'h66, "hold2");
    check("hold_yq_const", yq8, hold_yq);
    check("hold_sq_const", sq8, 1'b1);

    // Select-change sequence starting from a loaded S=0
    step8(1'b1, 1'b0, 8'h01, 8'h02, "seq_pre");
    for (int i = 0; i < 5; i++) begin
      step8(1'b1, seq_s[i], 8'h10 + 8'(i), 8'h80 + 8'(i), $sformatf("seq_%0d", i));
      check($sformatf("seq_chg_%0d", i), sc8, seq_chg[i]);
    end

    // Async reset between edges
    step8(1'b1, 1'b1, 8'hA5, 8'h3C, "pre_rst");
    @(negedge clk);
    en8 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_yq", yq8, 8'h00);
    check("arst_sq", sq8, 1'b0);
    check("arst_selchg", sc8, 1'b0);
    check("arst_y", y8, 8'h3C);
    m_yq = 8'h00; m_sq = 1'b0; m_sc = 1'b0;
    @(posedge clk);
    #1 check("arst_hold_yq", yq8, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step8(1'b1, 1'b1, 8'hA5, 8'h3C, "post_rst");
    check("post_rst_chg", sc8, 1'b1);

    // Unknown select: equal bits of A and B survive the merge
    step8(1'b0, 1'bx, 8'hFF, 8'hFF, "xsel_eq");
    check("xsel_eq_lit", y8, 8'hFF);
    step8(1'b0, 1'bx, 8'h0F, 8'hFF, "xsel_ne");
    check("xsel_lo_nib", {60'd0, y8[3:0]}, 64'hF);
    step8(1'b1, 1'b0, 8'h00, 8'h00, "xsel_exit");

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic r_en, r_s;
      logic [7:0] r_a, r_b;
      r_en = 1'($urandom_range(0, 3) != 0);
      r_s  = 1'($urandom_range(0, 1));
      r_a  = 8'($urandom);
      r_b  = 8'($urandom);
      step8(r_en, r_s, r_a, r_b, $sformatf("rnd_%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
